// File: rtl/frame_sequencer.sv
// Sequences one edge-filter pass: raster-order source reads, destination addresses for filter results.
// rd_req rises two cycles after start is sampled high; reads stall while buffered results reach PEND_THRESH.
module frame_sequencer #(
    parameter int BUSWIDTH    = 32,
    parameter int PIX_BYTES   = 1,
    parameter int MAX_DIM     = 1024,
    parameter int PEND_MAX    = 8,
    parameter int PEND_THRESH = 5
) (
    input  logic                ahb_hclk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [BUSWIDTH-1:0] width,
    input  logic [BUSWIDTH-1:0] height,
    input  logic [BUSWIDTH-1:0] read_start,
    input  logic [BUSWIDTH-1:0] write_start,
    output logic                rd_req,
    output logic [BUSWIDTH-1:0] rd_addr,
    input  logic                rd_ack,
    input  logic                flt_valid,
    output logic                wr_req,
    output logic [BUSWIDTH-1:0] wr_addr,
    input  logic                wr_ack,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic                ovf
);
    localparam int PW = $clog2(PEND_MAX + 1);
    localparam logic [BUSWIDTH-1:0] ONE   = BUSWIDTH'(1);
    localparam logic [BUSWIDTH-1:0] TWO   = BUSWIDTH'(2);
    localparam logic [BUSWIDTH-1:0] MIN_D = BUSWIDTH'(3);
    localparam logic [BUSWIDTH-1:0] MAX_D = BUSWIDTH'(MAX_DIM);
    localparam logic [BUSWIDTH-1:0] STEP  = BUSWIDTH'(PIX_BYTES);
    localparam logic [PW-1:0]       P_ONE = PW'(1);
    localparam logic [PW-1:0]       P_MAX = PW'(PEND_MAX);
    localparam logic [PW-1:0]       P_THR = PW'(PEND_THRESH);

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE, ERROR} state_t;
    state_t state, state_nxt;

    logic                start_q, start_d;
    logic                trig, dims_bad, last_pix;
    logic                rd_fire, wr_fire, flt_in, flt_acc, flt_drop;
    logic [BUSWIDTH-1:0] w_l, h_l, col, row;
    logic [BUSWIDTH-1:0] rd_cnt, wr_cnt, pix_total, wr_total;
    logic [PW-1:0]       pend_cnt;

    // Only a rising edge of the registered start launches a frame.
    assign trig     = start_q & ~start_d;
    assign dims_bad = (w_l < MIN_D) || (h_l < MIN_D) || (w_l > MAX_D) || (h_l > MAX_D);
    assign last_pix = (row == h_l - ONE) && (col == w_l - ONE);
    assign rd_fire  = rd_req & rd_ack;
    assign wr_fire  = wr_req & wr_ack;
    assign flt_in   = flt_valid & ((state == RUN) | (state == DRAIN));
    assign flt_acc  = flt_in & (pend_cnt != P_MAX);
    assign flt_drop = flt_in & (pend_cnt == P_MAX);

    always_ff @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_err   = 1'b0;
        case (state)
            IDLE: begin
                if (trig) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (!start_q)      state_nxt = IDLE;
                else if (dims_bad) state_nxt = ERROR;
                else               state_nxt = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                rd_req = (rd_cnt < pix_total) && (pend_cnt < P_THR);
                wr_req = (pend_cnt != '0);
                if (!start_q)                        state_nxt = IDLE;
                else if (rd_req && rd_ack && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                wr_req = (pend_cnt != '0);
                if (!start_q)                                    state_nxt = IDLE;
                else if ((wr_cnt == wr_total) && (pend_cnt == '0)) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start_q) state_nxt = IDLE;
            end
            ERROR: begin
                cfg_err = 1'b1;
                if (!start_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            start_q   <= 1'b0;
            start_d   <= 1'b0;
            w_l       <= '0;
            h_l       <= '0;
            col       <= '0;
            row       <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            pix_total <= '0;
            wr_total  <= '0;
            pend_cnt  <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            ovf       <= 1'b0;
        end else begin
            start_q <= start;
            start_d <= start_q;
            if (flt_drop) ovf <= 1'b1;
            if (state_nxt == IDLE) begin
                col      <= '0;
                row      <= '0;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                pend_cnt <= '0;
                rd_addr  <= '0;
                wr_addr  <= '0;
            end else if (state == IDLE) begin
                w_l     <= width;
                h_l     <= height;
                rd_addr <= read_start;
                wr_addr <= write_start;
            end else begin
                // Frame totals are derived once from the latched dimensions.
                if (state == CHECK) begin
                    pix_total <= w_l * h_l;
                    wr_total  <= (w_l - TWO) * (h_l - TWO);
                end
                if (rd_fire) begin
                    rd_addr <= rd_addr + STEP;
                    rd_cnt  <= rd_cnt + ONE;
                    if (col == w_l - ONE) begin
                        col <= '0;
                        row <= row + ONE;
                    end else begin
                        col <= col + ONE;
                    end
                end
                if (wr_fire) begin
                    wr_addr <= wr_addr + STEP;
                    wr_cnt  <= wr_cnt + ONE;
                end
                if (flt_acc && !wr_fire)      pend_cnt <= pend_cnt + P_ONE;
                else if (!flt_acc && wr_fire) pend_cnt <= pend_cnt - P_ONE;
            end
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus randomized frames against a phase-level reference model.
module tb_frame_sequencer;
    localparam int PM   = 8;
    localparam int PT   = 5;
    localparam int MAXD = 1024;
    localparam int PB   = 1;

    logic        ahb_hclk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] width = '0, height = '0, read_start = '0, write_start = '0;
    logic        rd_ack = 1'b0, flt_valid = 1'b0, wr_ack = 1'b0;
    logic        rd_req, wr_req, busy, done, cfg_err, ovf;
    logic [31:0] rd_addr, wr_addr;

    frame_sequencer #(.BUSWIDTH(32), .PIX_BYTES(PB), .MAX_DIM(MAXD), .PEND_MAX(PM), .PEND_THRESH(PT)) dut (
        .ahb_hclk(ahb_hclk), .n_rst(n_rst), .start(start), .width(width), .height(height),
        .read_start(read_start), .write_start(write_start), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .flt_valid(flt_valid), .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .busy(busy), .done(done), .cfg_err(cfg_err), .ovf(ovf));

    always #5 ahb_hclk = ~ahb_hclk;

    int n_chk = 0, n_fail = 0;
    logic [31:0] rd_log[$], wr_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_CHECK, M_RUN, M_DRAIN, M_DONE, M_ERR} mph_t;
    mph_t        ph;
    bit          s_q, s_qq, movf, m_rf, m_wf, m_dn;
    int unsigned mw, mh, nrd, nwr, npend;
    logic [31:0] mrb, mwb;

    function automatic bit m_rd_req();
        return (ph == M_RUN) && (npend < PT) && (nrd < mw * mh);
    endfunction
    function automatic bit m_wr_req();
        return ((ph == M_RUN) || (ph == M_DRAIN)) && (npend > 0);
    endfunction
    function automatic logic [31:0] m_rd_addr();
        return (ph == M_IDLE) ? 32'h0 : mrb + 32'(nrd * PB);
    endfunction
    function automatic logic [31:0] m_wr_addr();
        return (ph == M_IDLE) ? 32'h0 : mwb + 32'(nwr * PB);
    endfunction
    function automatic logic [5:0] m_flags();
        return {m_rd_req(), m_wr_req(), (ph == M_CHECK || ph == M_RUN || ph == M_DRAIN),
                ph == M_DONE, ph == M_ERR, movf};
    endfunction

    task automatic m_clear();
        ph = M_IDLE; nrd = 0; nwr = 0; npend = 0;
    endtask

    always @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            m_clear();
            s_q = 0; s_qq = 0; movf = 0; mw = 0; mh = 0; mrb = 0; mwb = 0;
        end else begin
            m_rf = m_rd_req() && rd_ack;
            m_wf = m_wr_req() && wr_ack;
            case (ph)
                M_IDLE: if (s_q && !s_qq) begin
                    mw = width; mh = height; mrb = read_start; mwb = write_start;
                    nrd = 0; nwr = 0; npend = 0; ph = M_CHECK;
                end
                M_CHECK: begin
                    if (!s_q) m_clear();
                    else if (mw < 3 || mh < 3 || mw > MAXD || mh > MAXD) ph = M_ERR;
                    else ph = M_RUN;
                end
                M_RUN, M_DRAIN: begin
                    if (flt_valid && npend == PM) movf = 1;
                    if (!s_q) m_clear();
                    else begin
                        m_dn = (ph == M_DRAIN) && (nwr == (mw - 2) * (mh - 2)) && (npend == 0);
                        if (flt_valid && npend < PM) npend++;
                        if (m_wf) begin npend--; nwr++; end
                        if (m_rf) begin
                            nrd++;
                            if (nrd == mw * mh) ph = M_DRAIN;
                        end
                        if (m_dn) ph = M_DONE;
                    end
                end
                default: if (!s_q) m_clear();
            endcase
            s_qq = s_q;
            s_q  = start;
        end
    end

    // Outputs change only after a posedge; compare mid-cycle.
    always @(negedge ahb_hclk) begin
        chk("flags{rd_req,wr_req,busy,done,cfg_err,ovf}",
            {26'h0, rd_req, wr_req, busy, done, cfg_err, ovf}, {26'h0, m_flags()});
        chk("rd_addr", rd_addr, m_rd_addr());
        chk("wr_addr", wr_addr, m_wr_addr());
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        if (rd_req && rd_ack) rd_log.push_back(rd_addr);
        if (wr_req && wr_ack) wr_log.push_back(wr_addr);
        @(negedge ahb_hclk);
        #1;
    endtask

    task automatic setup(input logic [31:0] w, h, rb, wb);
        width = w; height = h; read_start = rb; write_start = wb;
        rd_log.delete(); wr_log.delete();
    endtask

    task automatic drop_start();
        start = 0; rd_ack = 0; wr_ack = 0; flt_valid = 0;
        repeat (3) tick();
        chk("idle_after_drop", {29'h0, busy, done, cfg_err}, 32'h0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin tick(); n++; end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int flt_sent, n, target;
        bit ok;
        n_rst = 0;
        repeat (3) tick();
        chk("rst_flags", {26'h0, rd_req, wr_req, busy, done, cfg_err, ovf}, 32'h0);
        chk("rst_rd_addr", rd_addr, 32'h0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        n_rst = 1;
        tick();

        // T1: 4x4, acks every cycle, four filter outputs
        setup(4, 4, 32'h100, 32'h800);
        rd_ack = 1; wr_ack = 1; start = 1;
        tick(); tick();
        chk("t1_rd_req_before", rd_req, 0);
        tick();
        chk("t1_rd_req_rise", rd_req, 1);
        chk("t1_first_addr", rd_addr, 32'h100);
        flt_sent = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            flt_valid = (rd_log.size() >= 8) && (flt_sent < 4);
            if (flt_valid) flt_sent++;
            tick();
        end
        flt_valid = 0;
        chk("t1_done", done, 1);
        chk("t1_reads", rd_log.size(), 16);
        chk("t1_rd_first", rd_log[0], 32'h100);
        chk("t1_rd_last", rd_log[15], 32'h10F);
        chk("t1_writes", wr_log.size(), 4);
        chk("t1_wr_first", wr_log[0], 32'h800);
        chk("t1_wr_last", wr_log[3], 32'h803);
        chk("t1_ovf", ovf, 0);
        drop_start();

        // T2: illegal width
        setup(2, 5, 32'h40, 32'h80);
        start = 1;
        tick(); tick();
        chk("t2_err_early", cfg_err, 0);
        tick();
        chk("t2_err", cfg_err, 1);
        ok = 1;
        repeat (6) begin ok &= !rd_req; tick(); end
        chk("t2_no_rd_req", ok, 1);
        start = 0; tick(); tick();
        chk("t2_err_clear", cfg_err, 0);

        // T3: write side stalled, filter output per read from the third row
        setup(8, 8, 32'h1000, 32'h4000);
        rd_ack = 1; wr_ack = 0; start = 1;
        repeat (120) begin
            flt_valid = rd_req && rd_ack && (rd_log.size() >= 16);
            tick();
        end
        flt_valid = 0;
        chk("t3_reads_held", rd_log.size(), 21);
        chk("t3_rd_req_low", rd_req, 0);
        rd_ack = 0; wr_ack = 1;
        tick();
        chk("t3_rd_req_back", rd_req, 1);
        chk("t3_wr_addr", wr_addr, 32'h4001);
        drop_start();

        // T4: simultaneous filter output and write accept at pend=3
        setup(4, 4, 32'h200, 32'h900);
        start = 1;
        repeat (3) tick();
        flt_valid = 1;
        repeat (3) tick();
        chk("t4_wr_req", wr_req, 1);
        chk("t4_wr_addr0", wr_addr, 32'h900);
        wr_ack = 1;
        tick();
        flt_valid = 0;
        chk("t4_wr_addr1", wr_addr, 32'h901);
        repeat (3) tick();
        chk("t4_wr_addr4", wr_addr, 32'h904);
        chk("t4_drained", wr_req, 0);
        rd_ack = 1;
        wait_done(100);
        drop_start();

        // T5: overflow past PEND_MAX
        setup(8, 8, 32'h0, 32'h0);
        start = 1;
        repeat (3) tick();
        flt_valid = 1;
        repeat (PM) tick();
        chk("t5_ovf_at_max", ovf, 0);
        tick();
        chk("t5_ovf_set", ovf, 1);
        tick();
        flt_valid = 0;
        chk("t5_ovf_hold", ovf, 1);
        drop_start();
        chk("t5_ovf_sticky", ovf, 1);

        // Async reset mid-frame
        setup(5, 5, 32'h300, 32'h600);
        start = 1; rd_ack = 1;
        repeat (6) tick();
        #2 n_rst = 0; start = 0; rd_ack = 0;
        #1;
        chk("arst_flags", {26'h0, rd_req, wr_req, busy, done, cfg_err, ovf}, 32'h0);
        chk("arst_rd_addr", rd_addr, 32'h0);
        tick(); tick();
        n_rst = 1;
        tick();

        // T6: abort at the 7th read, then restart
        setup(4, 4, 32'h100, 32'h800);
        start = 1; rd_ack = 1;
        n = 0;
        while (rd_log.size() < 7 && n < 50) begin tick(); n++; end
        chk("t6_seven_reads", rd_log.size(), 7);
        start = 0;
        n = 0;
        while (busy && n < 5) begin tick(); n++; end
        chk("t6_abort_cycles", n, 2);
        chk("t6_rd_req", rd_req, 0);
        start = 1;
        tick(); tick();
        chk("t6_restart_wait", rd_req, 0);
        tick();
        chk("t6_restart_req", rd_req, 1);
        chk("t6_restart_addr", rd_addr, 32'h100);
        drop_start();

        // Randomized frames, including wrap-around bases and illegal sizes
        for (int f = 0; f < 12; f++) begin
            logic [31:0] w, h;
            bit valid;
            w = $urandom_range(3, 7);
            h = $urandom_range(3, 6);
            if (f % 5 == 4) w = (f % 2 == 1) ? 32'd1025 : 32'($urandom_range(0, 2));
            valid = (w >= 3 && w <= MAXD && h >= 3 && h <= MAXD);
            target = valid ? int'((w - 2) * (h - 2)) : 0;
            setup(w, h, (f % 3 == 0) ? 32'hFFFF_FFF8 : $urandom,
                  (f % 4 == 1) ? 32'hFFFF_FFFE : $urandom);
            start = 1;
            flt_sent = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c == 5) begin width = $urandom; height = $urandom; read_start = $urandom; end
                rd_ack = ($urandom_range(0, 3) != 0);
                wr_ack = ($urandom_range(0, 2) != 0);
                flt_valid = (ph == M_RUN || ph == M_DRAIN) && (flt_sent < target) &&
                            (npend < PM) && ($urandom_range(0, 2) == 0);
                if (flt_valid) flt_sent++;
                tick();
                if (done || cfg_err) break;
            end
            chk("rand_outcome", {30'h0, done, cfg_err}, valid ? 32'h2 : 32'h1);
            drop_start();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
